mem_cache_ctrl: RTL and testbench

- Direct-mapped, write-through, single-byte-line cache controller.
- Sits directly upstream of main memory and between the CPU/datapath and the memory port (rd_mem/wr_mem/addr_mem/data_in/data_out/ready_mem).
- Serves read hits locally and turns misses and all writes into single-access memory transactions.
- Holds a small tag/valid/data array and exports saturating hit/miss statistics.

---
 rtl/mem_cache_pkg.sv | 19 +
 rtl/mem_cache_ctrl_if.sv | 39 +++
 rtl/mem_cache_ctrl_tag_array.sv | 61 ++++++
 rtl/mem_cache_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mem_cache_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_cache_pkg.sv
// mem_cache_pkg
//   Shared types and helpers for the mem_cache_ctrl cache controller.
//   - cache_state_t : controller FSM states (3-bit encoding)
//   - tag_width()   : tag field width derived from address and index widths
package mem_cache_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    RESP   = 3'd4
  } cache_state_t;

  function automatic int tag_width(input int awidth, input int index_w);
    return awidth - index_w;
  endfunction

endpackage

// File: rtl/mem_cache_ctrl_if.sv
// mem_cache_ctrl_if
//   Bundles the CPU request/response bus and the main-memory port of the
//   cache controller.
//   CPU side    : cpu_rd, cpu_wr, cpu_addr, cpu_wdata -> cache
//                 cpu_rdata, cpu_ready               <- cache
//   Memory side : rd_mem, wr_mem, addr_mem, data_in  <- cache
//                 data_out, ready_mem                -> cache
//   Modports    : slave  = the cache controller
//                 master = the CPU plus memory environment driving it
interface mem_cache_ctrl_if #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 8
);

  logic              cpu_rd;
  logic              cpu_wr;
  logic [AWIDTH-1:0] cpu_addr;
  logic [DWIDTH-1:0] cpu_wdata;
  logic [DWIDTH-1:0] cpu_rdata;
  logic              cpu_ready;

  logic              rd_mem;
  logic              wr_mem;
  logic [AWIDTH-1:0] addr_mem;
  logic [DWIDTH-1:0] data_in;
  logic [DWIDTH-1:0] data_out;
  logic              ready_mem;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, data_out, ready_mem,
    output cpu_rdata, cpu_ready, rd_mem, wr_mem, addr_mem, data_in
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, data_out, ready_mem,
    input  cpu_rdata, cpu_ready, rd_mem, wr_mem, addr_mem, data_in
  );

endinterface

// File: rtl/mem_cache_ctrl_tag_array.sv
// cache_tag_array
//   Tag/valid/data storage for the direct-mapped cache.
//   Ports:
//     clk, reset          clock and async active-high reset (clears valid bits)
//     rd_index            line to look at
//     rd_valid/tag/data   combinational view of that line
//     wr_en               write wr_data into data_arr[wr_index] this edge
//     wr_fill             together with wr_en: also write the tag and set valid
//     wr_index/tag/data   write port fields
module cache_tag_array
  import mem_cache_pkg::*;
#(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = tag_width(9, 4),
  parameter int DWIDTH  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DWIDTH-1:0]  rd_data,
  input  logic               wr_en,
  input  logic               wr_fill,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DWIDTH-1:0]  wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DWIDTH-1:0] data_q [LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

  // Valid bits are the only storage that reset touches, so a reset
  // invalidates the whole cache without clearing the arrays themselves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en && wr_fill) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; a line is only trusted once its
  // valid bit has been set by a fill.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_index] <= wr_data;
      if (wr_fill) begin
        tag_q[wr_index] <= wr_tag;
      end
    end
  end

endmodule

// File: rtl/mem_cache_ctrl.sv
// mem_cache_ctrl
//   Direct-mapped, write-through, single-byte-line cache controller placed
//   between a CPU and main memory. Read hits are answered locally, read
//   misses refill one line from memory, and every write goes to memory
//   (updating the cached copy only if the line is already present).
//   Ports:
//     clk, reset          clock and async active-high reset
//     bus (slave)         CPU request/response and memory port, see mem_cache_ctrl_if
//     hit_cnt, miss_cnt   saturating read hit/miss counters
module mem_cache_ctrl
  import mem_cache_pkg::*;
#(
  parameter int AWIDTH  = 9,
  parameter int DWIDTH  = 8,
  parameter int INDEX_W = 4,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  mem_cache_ctrl_if.slave  bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int TAG_W = tag_width(AWIDTH, INDEX_W);
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  cache_state_t state_q, state_d;

  logic [AWIDTH-1:0]  req_addr_q;
  logic [DWIDTH-1:0]  req_wdata_q;
  logic               req_wr_q;
  logic [LAT_W-1:0]   lat_q;

  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [DWIDTH-1:0]  line_data;
  logic               line_hit;
  logic               last_beat;

  logic               arr_wr_en;
  logic               arr_fill;
  logic [DWIDTH-1:0]  arr_wdata;

  assign req_index = req_addr_q[INDEX_W-1:0];
  assign req_tag   = req_addr_q[AWIDTH-1:INDEX_W];
  assign line_hit  = line_valid && (line_tag == req_tag);
  assign last_beat = (lat_q == '0);

  cache_tag_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DWIDTH  (DWIDTH)
  ) u_tags (
    .clk      (clk),
    .reset    (reset),
    .rd_index (req_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (arr_wr_en),
    .wr_fill  (arr_fill),
    .wr_index (req_index),
    .wr_tag   (req_tag),
    .wr_data  (arr_wdata)
  );

  // Next-state and array write controls. The array write happens on the
  // final memory beat: a read fill installs tag+data+valid, a write only
  // refreshes the data if the line is currently cached.
  always_comb begin
    state_d   = state_q;
    arr_wr_en = 1'b0;
    arr_fill  = 1'b0;
    arr_wdata = req_wdata_q;
    unique case (state_q)
      IDLE: begin
        if ((bus.cpu_rd || bus.cpu_wr) && bus.ready_mem) begin
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (req_wr_q) begin
          state_d = MEM_WR;
        end else if (line_hit) begin
          state_d = RESP;
        end else begin
          state_d = MEM_RD;
        end
      end
      MEM_RD: begin
        arr_wdata = bus.data_out;
        if (last_beat) begin
          state_d   = RESP;
          arr_wr_en = 1'b1;
          arr_fill  = 1'b1;
        end
      end
      MEM_WR: begin
        if (last_beat) begin
          state_d   = RESP;
          arr_wr_en = line_hit;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register plus request capture. A simultaneous read+write request
  // is treated as a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == LOOKUP) begin
        req_addr_q  <= bus.cpu_addr;
        req_wdata_q <= bus.cpu_wdata;
        req_wr_q    <= bus.cpu_wr;
      end
    end
  end

  // Memory beat down-counter: loaded while leaving LOOKUP so it reads
  // MEM_LAT-1 in the first strobe cycle and zero in the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_q <= '0;
    end else if (state_q == LOOKUP) begin
      lat_q <= LAT_LOAD;
    end else if ((state_q == MEM_RD || state_q == MEM_WR) && !last_beat) begin
      lat_q <= lat_q - LAT_W'(1);
    end
  end

  // Bus-facing outputs are registered from the next state so that strobes
  // and cpu_ready line up exactly with the MEM_*/RESP cycles and never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rd_mem    <= 1'b0;
      bus.wr_mem    <= 1'b0;
      bus.addr_mem  <= '0;
      bus.data_in   <= '0;
      bus.cpu_ready <= 1'b0;
    end else begin
      bus.rd_mem    <= (state_d == MEM_RD);
      bus.wr_mem    <= (state_d == MEM_WR);
      bus.addr_mem  <= (state_d == MEM_RD || state_d == MEM_WR) ? req_addr_q : '0;
      bus.data_in   <= (state_d == MEM_WR) ? req_wdata_q : '0;
      bus.cpu_ready <= (state_d == RESP);
    end
  end

  // Read data comes from the array on a hit or straight from memory on the
  // last fill beat; it is held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cpu_rdata <= '0;
    end else if (state_q == LOOKUP && !req_wr_q && line_hit) begin
      bus.cpu_rdata <= line_data;
    end else if (state_q == MEM_RD && last_beat) begin
      bus.cpu_rdata <= bus.data_out;
    end
  end

  // Hit/miss statistics, counted once per read at lookup time and held at
  // all-ones once full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_q == LOOKUP && !req_wr_q) begin
      if (line_hit) begin
        if (hit_cnt != CNT_MAX) begin
          hit_cnt <= hit_cnt + CNT_W'(1);
        end
      end else if (miss_cnt != CNT_MAX) begin
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// tb_mem_cache_ctrl
//   Self-checking bench for mem_cache_ctrl (MEM_LAT=3, CNT_W=4). A simple
//   memory model sits on the memory port; a transaction-level reference
//   model predicts, per cycle after acceptance, which strobes and responses
//   must be visible, and one compare process checks them every cycle.
module tb_mem_cache_ctrl;

  localparam int AW      = 9;
  localparam int DW      = 8;
  localparam int IW      = 4;
  localparam int LAT     = 3;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  int test_count = 0;
  int fail_count = 0;

  mem_cache_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  mem_cache_ctrl #(
    .AWIDTH  (AW),
    .DWIDTH  (DW),
    .INDEX_W (IW),
    .MEM_LAT (LAT),
    .CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Deterministic power-on memory contents, shared by memory and model.
  function automatic logic [7:0] init_val(input int a);
    if (a == 'h025) return 8'hA5;
    if (a == 'h045) return 8'h77;
    return 8'(a * 37 + 11);
  endfunction

  // Main memory: combinational read, write on every strobed edge.
  logic [7:0] mem [512];
  logic       mem_ready = 1'b0;

  assign bus.data_out = mem[bus.addr_mem];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (bus.wr_mem) begin
      mem[bus.addr_mem] <= bus.data_in;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: cache contents, memory image, counters, and the
  // current transaction described by its cycle number k after acceptance
  // (k=1 lookup cycle, strobes in k=2..LAT+1 for misses/writes, response at
  // ready_k).
  logic [7:0] ref_mem   [512];
  logic       ref_valid [16];
  logic [4:0] ref_tag   [16];
  logic [7:0] ref_data  [16];
  logic       model_init_done = 1'b0;
  logic       busy;
  int         k, ready_k;
  logic       t_wr, t_hit;
  logic [8:0] t_addr;
  logic [7:0] t_wdata, t_rdata;
  int         exp_hit, exp_miss;

  task automatic modelStep();
    if (!model_init_done) begin
      for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
      model_init_done = 1'b1;
    end
    if (reset) begin
      busy = 1'b0;
      k = 0;
      ready_k = 0;
      t_wr = 1'b0;
      t_hit = 1'b0;
      exp_hit = 0;
      exp_miss = 0;
      for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    end else if (busy) begin
      if (k == ready_k) begin
        busy = 1'b0;
      end else begin
        k++;
        if (k == 2 && !t_wr) begin
          if (t_hit) begin
            if (exp_hit < CNT_MAX) exp_hit++;
          end else if (exp_miss < CNT_MAX) begin
            exp_miss++;
          end
        end
        if (k == ready_k && t_wr) begin
          ref_mem[t_addr] = t_wdata;
          if (t_hit) ref_data[t_addr[3:0]] = t_wdata;
        end else if (k == ready_k && !t_hit) begin
          ref_valid[t_addr[3:0]] = 1'b1;
          ref_tag[t_addr[3:0]]   = t_addr[8:4];
          ref_data[t_addr[3:0]]  = ref_mem[t_addr];
          t_rdata = ref_mem[t_addr];
        end
      end
    end else if ((bus.cpu_rd || bus.cpu_wr) && bus.ready_mem) begin
      busy    = 1'b1;
      k       = 1;
      t_wr    = bus.cpu_wr;
      t_addr  = bus.cpu_addr;
      t_wdata = bus.cpu_wdata;
      t_hit   = ref_valid[t_addr[3:0]] && (ref_tag[t_addr[3:0]] == t_addr[8:4]);
      t_rdata = ref_data[t_addr[3:0]];
      ready_k = (!t_wr && t_hit) ? 2 : 2 + LAT;
    end
  endtask

  always @(posedge clk or posedge reset) modelStep();

  // Per-cycle comparison of every DUT output against the model.
  logic exp_rd, exp_wr, exp_rdy;

  always @(negedge clk) begin
    if (!reset) begin
      exp_rd  = busy && !t_wr && !t_hit && k >= 2 && k <= LAT + 1;
      exp_wr  = busy && t_wr && k >= 2 && k <= LAT + 1;
      exp_rdy = busy && (k == ready_k);
      checkOutput("rd_mem", 32'(bus.rd_mem), 32'(exp_rd));
      checkOutput("wr_mem", 32'(bus.wr_mem), 32'(exp_wr));
      if (exp_rd || exp_wr) checkOutput("addr_mem", 32'(bus.addr_mem), 32'(t_addr));
      if (exp_wr) checkOutput("data_in", 32'(bus.data_in), 32'(t_wdata));
      checkOutput("cpu_ready", 32'(bus.cpu_ready), 32'(exp_rdy));
      if (exp_rdy && !t_wr) checkOutput("cpu_rdata", 32'(bus.cpu_rdata), 32'(t_rdata));
      checkOutput("hit_cnt", 32'(hit_cnt), 32'(exp_hit));
      checkOutput("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
    end
  end

  // Issue one request (optionally with ready_mem held low for 'stall'
  // cycles), hold it until cpu_ready, then leave one idle cycle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [8:0] addr,
                               input logic [7:0] wdata, input int stall,
                               output logic [7:0] rdata, output int lat,
                               output int rd_cycles, output int wr_cycles);
    int   stall_left;
    logic accepted, done, acc_pending;
    stall_left = stall;
    accepted   = 1'b0;
    done       = 1'b0;
    lat        = 0;
    rd_cycles  = 0;
    wr_cycles  = 0;
    rdata      = '0;
    bus.cpu_rd    = rd;
    bus.cpu_wr    = wr;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.ready_mem = (stall_left == 0);
    for (int c = 0; c < 40 && !done; c++) begin
      acc_pending = !accepted && bus.ready_mem;
      @(posedge clk);
      #1;
      if (acc_pending) begin
        accepted = 1'b1;
        lat = 1;
      end else if (accepted) begin
        lat++;
      end
      if (stall_left > 0) begin
        stall_left--;
        bus.ready_mem = (stall_left == 0);
      end
      if (bus.rd_mem) rd_cycles++;
      if (bus.wr_mem) wr_cycles++;
      if (bus.cpu_ready) begin
        done  = 1'b1;
        rdata = bus.cpu_rdata;
      end
    end
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
    checkOutput("req_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 300000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rdata;
    int         lat, rdc, wrc, mism, seen_ready;
    logic       op_rd, op_wr;
    logic [8:0] a;
    int         op;

    reset = 1'b1;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.ready_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_rd_mem", 32'(bus.rd_mem), 32'd0);
    checkOutput("rst_wr_mem", 32'(bus.wr_mem), 32'd0);
    checkOutput("rst_ready", 32'(bus.cpu_ready), 32'd0);
    checkOutput("rst_addr_mem", 32'(bus.addr_mem), 32'd0);
    checkOutput("rst_data_in", 32'(bus.data_in), 32'd0);
    checkOutput("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
    checkOutput("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    checkOutput("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Cold read miss, then the same address hits.
    applyStimulus(1'b1, 1'b0, 9'h025, 8'h00, 0, rdata, lat, rdc, wrc);
    checkOutput("cold_rdata", 32'(rdata), 32'hA5);
    checkOutput("cold_rd_cycles", 32'(rdc), 32'd3);
    checkOutput("cold_latency", 32'(lat), 32'd5);
    checkOutput("cold_miss_cnt", 32'(miss_cnt), 32'd1);
    checkOutput("cold_hit_cnt", 32'(hit_cnt), 32'd0);
    applyStimulus(1'b1, 1'b0, 9'h025, 8'h00, 0, rdata, lat, rdc, wrc);
    checkOutput("hit_rdata", 32'(rdata), 32'hA5);
    checkOutput("hit_rd_cycles", 32'(rdc), 32'd0);
    checkOutput("hit_latency", 32'(lat), 32'd2);
    checkOutput("hit_hit_cnt", 32'(hit_cnt), 32'd1);

    // Write-through with write-update of the cached line.
    applyStimulus(1'b0, 1'b1, 9'h025, 8'h3C, 0, rdata, lat, rdc, wrc);
    checkOutput("wr_wr_cycles", 32'(wrc), 32'd3);
    checkOutput("wr_rd_cycles", 32'(rdc), 32'd0);
    checkOutput("wr_mem_025", 32'(mem[9'h025]), 32'h3C);
    applyStimulus(1'b1, 1'b0, 9'h025, 8'h00, 0, rdata, lat, rdc, wrc);
    checkOutput("wr_hit_rdata", 32'(rdata), 32'h3C);
    checkOutput("wr_hit_rd_cycles", 32'(rdc), 32'd0);
    checkOutput("wr_hit_cnt", 32'(hit_cnt), 32'd2);

    // Conflict on index 5 evicts 0x025.
    applyStimulus(1'b1, 1'b0, 9'h045, 8'h00, 0, rdata, lat, rdc, wrc);
    checkOutput("conf_rdata", 32'(rdata), 32'h77);
    checkOutput("conf_rd_cycles", 32'(rdc), 32'd3);
    applyStimulus(1'b1, 1'b0, 9'h025, 8'h00, 0, rdata, lat, rdc, wrc);
    checkOutput("evict_rdata", 32'(rdata), 32'h3C);
    checkOutput("evict_rd_cycles", 32'(rdc), 32'd3);
    checkOutput("evict_miss_cnt", 32'(miss_cnt), 32'd3);

    // Read and write together behave as a write.
    applyStimulus(1'b1, 1'b1, 9'h010, 8'hFF, 0, rdata, lat, rdc, wrc);
    checkOutput("both_rd_cycles", 32'(rdc), 32'd0);
    checkOutput("both_wr_cycles", 32'(wrc), 32'd3);
    checkOutput("both_mem_010", 32'(mem[9'h010]), 32'hFF);
    checkOutput("both_hit_cnt", 32'(hit_cnt), 32'd2);
    checkOutput("both_miss_cnt", 32'(miss_cnt), 32'd3);

    // Reset during the second cycle of a memory read.
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 9'h033;
    rdc = 0;
    for (int c = 0; c < 10 && rdc == 0; c++) begin
      @(posedge clk);
      #1;
      if (bus.rd_mem) rdc = 1;
    end
    checkOutput("mid_rd_started", 32'(rdc), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("mid_rd_mem", 32'(bus.rd_mem), 32'd0);
    checkOutput("mid_ready", 32'(bus.cpu_ready), 32'd0);
    bus.cpu_rd = 1'b0;
    seen_ready = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.cpu_ready) seen_ready++;
    end
    reset = 1'b0;
    repeat (LAT + 2) begin
      @(posedge clk);
      #1;
      if (bus.cpu_ready) seen_ready++;
    end
    checkOutput("mid_no_ready", 32'(seen_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 9'h033, 8'h00, 0, rdata, lat, rdc, wrc);
    checkOutput("mid_refetch_rd_cycles", 32'(rdc), 32'd3);
    checkOutput("mid_refetch_miss", 32'(miss_cnt), 32'd1);

    // Hit counter saturation.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 9'h033, 8'h00, 0, rdata, lat, rdc, wrc);
    end
    checkOutput("sat_hit_cnt", 32'(hit_cnt), 32'd15);
    checkOutput("sat_miss_cnt", 32'(miss_cnt), 32'd1);

    // Randomized traffic from a fresh reset, with ready_mem stalls.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int n = 0; n < 250; n++) begin
      op    = int'($urandom_range(0, 3));
      op_rd = (op != 2);
      op_wr = (op >= 2);
      a     = {5'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      applyStimulus(op_rd, op_wr, a, 8'($urandom), int'($urandom_range(0, 2)),
                    rdata, lat, rdc, wrc);
      repeat (int'($urandom_range(0, 2))) @(posedge clk);
      #1;
    end

    mism = 0;
    for (int i = 0; i < 512; i++) begin
      if (mem[i] !== ref_mem[i]) mism++;
    end
    checkOutput("mem_image", 32'(mism), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
